// File: rtl/mfu_seq_ctrl.sv
// Sequencer feeding a shared precision-configurable multiplier and accumulating a signed dot product.
// Optional abort input is compiled in when MFU_SEQ_CTRL_ABORT_EN is defined.
module mfu_seq_ctrl (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [1:0]  cfg_mode,
    input  logic [7:0]  cfg_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mfu_a,
    output logic [7:0]  mfu_b,
    output logic [1:0]  mfu_mode,
    input  logic [15:0] mfu_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_acc,
    output logic        busy
`ifdef MFU_SEQ_CTRL_ABORT_EN
    ,
    input  logic        abort
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  mode_r;
    logic [7:0]  len_r;
    logic [7:0]  cnt_r;
    logic        pv_r;
    logic [23:0] acc_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;
    logic        accept_s;
    logic        last_s;
    logic        abort_s;
    logic        job_s;

    // Sign-extended sum of the packed lane products for the latched precision.
    function automatic logic [23:0] lane_sum(input logic [1:0] mode, input logic [15:0] p);
        logic [23:0] s;
        s = 24'd0;
        case (mode)
            2'd1: s = {{8{p[15]}}, p};
            2'd2: s = {{16{p[15]}}, p[15:8]} + {{16{p[7]}}, p[7:0]};
            2'd3: s = {{20{p[15]}}, p[15:12]} + {{20{p[11]}}, p[11:8]}
                    + {{20{p[7]}}, p[7:4]} + {{20{p[3]}}, p[3:0]};
            default: s = 24'd0;
        endcase
        return s;
    endfunction

    assign accept_s = in_valid && in_ready_r;
    assign last_s   = accept_s && (({1'b0, cnt_r} + 9'd1) == {1'b0, len_r});
    assign job_s    = (state_r == IDLE) && start;

`ifdef MFU_SEQ_CTRL_ABORT_EN
    assign abort_s = abort && ((state_r == RUN) || (state_r == DRAIN));
`else
    assign abort_s = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if ((cfg_mode != 2'd0) && (cfg_len != 8'd0)) begin
                        state_s = RUN;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operands reach the multiplier only on an accepted beat; otherwise it idles in NOOP.
    always_comb begin
        mfu_a    = 8'd0;
        mfu_b    = 8'd0;
        mfu_mode = 2'd0;
        if (accept_s) begin
            mfu_a    = in_a;
            mfu_b    = in_b;
            mfu_mode = mode_r;
        end else begin
            mfu_a    = 8'd0;
            mfu_b    = 8'd0;
            mfu_mode = 2'd0;
        end
    end

    // State, job configuration, beat counter, product-valid flag and accumulator.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= IDLE;
            mode_r      <= 2'd0;
            len_r       <= 8'd0;
            cnt_r       <= 8'd0;
            pv_r        <= 1'b0;
            acc_r       <= 24'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == RUN);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
            pv_r        <= accept_s && !abort_s;
            if (job_s) begin
                mode_r <= cfg_mode;
                len_r  <= cfg_len;
                cnt_r  <= 8'd0;
                acc_r  <= 24'd0;
            end else if (abort_s) begin
                cnt_r  <= 8'd0;
                acc_r  <= 24'd0;
            end else begin
                if (accept_s) begin
                    cnt_r <= cnt_r + 8'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
                // Product of the beat accepted on the previous edge lands now.
                if (pv_r) begin
                    acc_r <= acc_r + lane_sum(mode_r, mfu_p);
                end else begin
                    acc_r <= acc_r;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_acc   = acc_r;

endmodule

// File: tb/tb_mfu_seq_ctrl.sv
// Self-checking bench for mfu_seq_ctrl: directed vector table, corner sequences and random jobs
// against an arithmetic dot-product model. Abort tests build when MFU_SEQ_CTRL_ABORT_EN is defined.
module tb_mfu_seq_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [7:0]  cfg_len = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic [7:0]  mfu_a;
    logic [7:0]  mfu_b;
    logic [1:0]  mfu_mode;
    logic [15:0] mfu_p = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_acc;
    logic        busy;
`ifdef MFU_SEQ_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] ja [0:255];
    logic [7:0] jb [0:255];

    mfu_seq_ctrl dut (
        .clk(clk), .nrst(nrst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mfu_a(mfu_a), .mfu_b(mfu_b), .mfu_mode(mfu_mode), .mfu_p(mfu_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .busy(busy)
`ifdef MFU_SEQ_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // Signed field k of width w taken from an 8-bit operand.
    function automatic int field(input logic [7:0] x, input int k, input int w);
        int v;
        v = (int'(x) >> (k * w)) & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v -= (1 << w);
        return v;
    endfunction

    function automatic int lane_width(input logic [1:0] mode);
        return 8 >> (int'(mode) - 1);
    endfunction

    // Reference: signed dot product of the lanes of one beat.
    function automatic int dot(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b);
        int s, w;
        s = 0;
        if (mode == 2'd0) return 0;
        w = lane_width(mode);
        for (int k = 0; k < 8 / w; k++) s += field(a, k, w) * field(b, k, w);
        return s;
    endfunction

    // Behaviour of the attached multiplier: packed per-lane products.
    function automatic logic [15:0] pack(input logic [1:0] mode, input logic [7:0] a, input logic [7:0] b);
        int w, pr;
        logic [15:0] p;
        p = 16'd0;
        if (mode == 2'd0) return p;
        w = lane_width(mode);
        for (int k = 0; k < 8 / w; k++) begin
            pr = field(a, k, w) * field(b, k, w);
            p  = p | 16'((pr & ((1 << (2 * w)) - 1)) << (k * 2 * w));
        end
        return p;
    endfunction

    always @(posedge clk) mfu_p <= pack(mfu_mode, mfu_a, mfu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run one job from IDLE; beats come from ja/jb.
    task automatic run_job(input logic [1:0] mode, input logic [7:0] len, input int gap_lo,
                           input int gap_hi, input int rdly, input bit start_in_gap,
                           input logic [23:0] exp, input string tag);
        int g;
        start = 1'b1; cfg_mode = mode; cfg_len = len;
        tick();
        start = 1'b0; cfg_mode = 2'd0; cfg_len = 8'd0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        if (mode != 2'd0 && len != 8'd0) begin
            for (int i = 0; i < int'(len); i++) begin
                g = $urandom_range(gap_hi, gap_lo);
                for (int j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    if (start_in_gap && i > 0 && j == 0) start = 1'b1;
                    #1;
                    check({tag, " gap_mode_noop"}, 32'(mfu_mode), 32'd0);
                    tick();
                    start = 1'b0;
                end
                in_valid = 1'b1; in_a = ja[i]; in_b = jb[i];
                #1;
                check({tag, " in_ready"}, 32'(in_ready), 32'd1);
                check({tag, " mfu_drive"}, {14'd0, mfu_mode, mfu_a, mfu_b}, {14'd0, mode, ja[i], jb[i]});
                tick();
                in_valid = 1'b0;
            end
            check({tag, " drain_no_valid"}, 32'(out_valid), 32'd0);
            tick();
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        for (int r = 0; r < rdly; r++) begin
            check({tag, " hold_acc"}, 32'(out_acc), 32'(exp));
            tick();
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check({tag, " out_acc"}, 32'(out_acc), 32'(exp));
        tick();
        out_ready = 1'b0;
        check({tag, " idle_after"}, {30'd0, busy, out_valid}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  len;
        logic [7:0]  a0, b0, a1, b1;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [1:0] m;
        logic [7:0] l;
        int sum;

        vecs[0] = '{2'd1, 8'd2, 8'h03, 8'hFC, 8'h80, 8'h80, 24'd16372};
        vecs[1] = '{2'd2, 8'd1, 8'h7F, 8'h9F, 8'h00, 8'h00, -24'sd48};
        vecs[2] = '{2'd3, 8'd1, 8'hE4, 8'hFF, 8'h00, 8'h00, 24'd2};
        vecs[3] = '{2'd1, 8'd0, 8'h11, 8'h11, 8'h00, 8'h00, 24'd0};
        vecs[4] = '{2'd0, 8'd3, 8'h11, 8'h11, 8'h00, 8'h00, 24'd0};
        vecs[5] = '{2'd1, 8'd1, 8'h80, 8'h7F, 8'h00, 8'h00, -24'sd16256};
        vecs[6] = '{2'd2, 8'd2, 8'h88, 8'h88, 8'h11, 8'hF2, 24'd129};
        vecs[7] = '{2'd3, 8'd2, 8'hAA, 8'hAA, 8'h55, 8'hAA, 24'd8};

        #2;
        check("reset_outputs", {27'd0, busy, in_ready, out_valid, mfu_mode}, 32'd0);
        check("reset_acc", 32'(out_acc), 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            ja[0] = vecs[v].a0; jb[0] = vecs[v].b0;
            ja[1] = vecs[v].a1; jb[1] = vecs[v].b1;
            run_job(vecs[v].mode, vecs[v].len, 0, 0, 1, 1'b0, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Gapped input, back-pressured output, start pulses during RUN.
        ja[0] = 8'd1; jb[0] = 8'd1; ja[1] = 8'd2; jb[1] = 8'd2; ja[2] = 8'd3; jb[2] = 8'd3;
        run_job(2'd1, 8'd3, 2, 2, 5, 1'b1, 24'd14, "gapped");

        // Reset in the middle of a job discards it.
        start = 1'b1; cfg_mode = 2'd1; cfg_len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5;
        tick();
        in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        check("midreset_state", {29'd0, busy, in_ready, out_valid}, 32'd0);
        check("midreset_acc", 32'(out_acc), 32'd0);
        tick();
        nrst = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midreset_quiet", {30'd0, out_valid, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        ja[0] = 8'd2; jb[0] = 8'd3;
        run_job(2'd1, 8'd1, 0, 1, 0, 1'b0, 24'd6, "post_reset");

`ifdef MFU_SEQ_CTRL_ABORT_EN
        start = 1'b1; cfg_mode = 2'd1; cfg_len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
        tick();
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {30'd0, busy, out_valid}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_quiet", 32'(out_valid), 32'd0);
        end
        ja[0] = 8'd2; jb[0] = 8'd3;
        run_job(2'd1, 8'd1, 0, 0, 0, 1'b0, 24'd6, "post_abort");
`endif

        // Random jobs against the arithmetic model.
        for (int t = 0; t < 24; t++) begin
            m = 2'($urandom_range(3, 1));
            l = 8'($urandom_range(10, 1));
            sum = 0;
            for (int i = 0; i < int'(l); i++) begin
                ja[i] = 8'($urandom);
                jb[i] = 8'($urandom);
                sum += dot(m, ja[i], jb[i]);
            end
            run_job(m, l, 0, 2, $urandom_range(3, 0), 1'b1, 24'(sum), $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
